// File: rtl/sm3_inpt_drvr_pkg.sv
// Purpose : shared types and helpers for the SM3 input-side message driver.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: drvr_state_e FSM encoding, BPW_DEF/BPW_MAX byte-per-word constants,
//           byte_mask() which builds the MSB-first byte-valid mask of a last beat.
package sm3_inpt_drvr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drvr_state_e;

  // Bytes per beat for the default 32-bit build; the widest supported beat is 64 bits.
  localparam int DW_DEF  = 32;
  localparam int BPW_DEF = DW_DEF / 8;
  localparam int BPW_MAX = 8;

  // Mask for a beat carrying 'rem' leading valid bytes out of 'bpw' lanes.
  // Lane 0 (first byte) maps to bit bpw-1, so valid bytes fill from the top.
  // rem == 0 means the beat is completely full.
  function automatic logic [BPW_MAX-1:0] byte_mask(input int bpw, input int rem);
    logic [BPW_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < BPW_MAX; i++) begin
      if (i < bpw && (rem == 0 || (bpw - 1 - i) < rem)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sm3_inpt_drvr_if.sv
// Purpose : beat stream between the message driver and the SM3 padder input.
// Latency : n/a (wires only).
// Backpr. : consumer drives inpt_rdy; a beat moves when inpt_vld & inpt_rdy.
// Signals : inpt_vld/inpt_d/inpt_byte_vld/inpt_lst from master, inpt_rdy from slave.
interface sm3_inpt_drvr_if #(
  parameter int DW = 32
) ();

  logic            inpt_vld;
  logic [DW-1:0]   inpt_d;
  logic [DW/8-1:0] inpt_byte_vld;
  logic            inpt_lst;
  logic            inpt_rdy;

  modport master (
    output inpt_vld,
    output inpt_d,
    output inpt_byte_vld,
    output inpt_lst,
    input  inpt_rdy
  );

  modport slave (
    input  inpt_vld,
    input  inpt_d,
    input  inpt_byte_vld,
    input  inpt_lst,
    output inpt_rdy
  );

endinterface

// File: rtl/sm3_inpt_drvr_lfsr.sv
// Purpose : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to insert launch bubbles.
// Latency : bit_o reflects the register state, one step per enabled cycle.
// Backpr. : none; steps only while en_i is high.
// Ports   : clk, rst_n (async active-low), en_i step enable, bit_o = LFSR[0].
// Built only when SM3_DRVR_BUBBLE_EN is defined.
`ifdef SM3_DRVR_BUBBLE_EN
module sm3_inpt_drvr_lfsr (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_o
);

  logic [15:0] lfsr_q;
  logic        fb;

  // Taps 16,14,13,11 counted from 1 at the MSB end of a left-shifting register.
  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

  assign bit_o = lfsr_q[0];

endmodule
`endif

// File: rtl/sm3_inpt_drvr.sv
// Purpose : message source for the SM3 padder; byte k of the message = seed + k (mod 256).
// Latency : first beat valid the cycle after start is accepted; then 1 beat/cycle while ready.
// Backpr. : presented beat holds stable until inpt_rdy; vld never drops without a handshake.
// Ports   : clk, rst_n (async active-low); start/msg_len/seed request (sampled in IDLE);
//           busy (SEND and DONE cycles), done (1-cycle pulse); inpt = beat stream master.
// Option  : SM3_DRVR_BUBBLE_EN adds LFSR-gated bubbles before launching a new beat.
module sm3_inpt_drvr
  import sm3_inpt_drvr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [7:0]       seed,
  output logic             busy,
  output logic             done,
  sm3_inpt_drvr_if.master  inpt
);

  localparam int BPW = DW / 8;
  localparam int RW  = $clog2(BPW);

  drvr_state_e      state_q;
  logic [LEN_W-1:0] last_idx_q;   // index of the final beat
  logic [BPW-1:0]   last_mask_q;  // byte-valid mask of the final beat
  logic [LEN_W-1:0] beat_q;       // index of the next beat to launch
  logic [7:0]       byte_q;       // first byte value of the next beat
  logic             vld_q;
  logic [DW-1:0]    dat_q;
  logic [BPW-1:0]   msk_q;
  logic             lst_q;
  logic             busy_q;
  logic             done_q;

  logic [BPW_MAX-1:0] mask_full;
  logic [BPW-1:0]     cap_mask;
  logic [LEN_W-1:0]   cap_last_idx;
  logic [7:0]         byte_d;
  logic               beat_lst_d;
  logic [BPW-1:0]     lmask_sel;
  logic [BPW-1:0]     beat_msk_d;
  logic [DW-1:0]      beat_dat_d;
  logic               launch_ok;
  logic               hs;
  logic               launch;

`ifdef SM3_DRVR_BUBBLE_EN
  sm3_inpt_drvr_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == SEND),
    .bit_o (launch_ok)
  );
`else
  assign launch_ok = 1'b1;
`endif

  assign hs = vld_q & inpt.inpt_rdy;

  // Contents of the beat that would be launched this cycle. In IDLE it is beat 0
  // built straight from the request inputs so vld can rise one cycle after start.
  always_comb begin
    mask_full    = byte_mask(BPW, int'(msg_len[RW-1:0]));
    cap_mask     = (msg_len == '0) ? '0 : mask_full[BPW-1:0];
    // (len-1)/BPW == ceil(len/BPW)-1; a zero-length message still sends one beat.
    cap_last_idx = (msg_len == '0) ? '0 : ((msg_len - LEN_W'(1)) >> RW);

    if (state_q == IDLE) begin
      byte_d     = seed;
      beat_lst_d = (cap_last_idx == '0);
      lmask_sel  = cap_mask;
    end else begin
      byte_d     = byte_q;
      beat_lst_d = (beat_q == last_idx_q);
      lmask_sel  = last_mask_q;
    end

    beat_msk_d = beat_lst_d ? lmask_sel : '1;

    beat_dat_d = '0;
    for (int i = 0; i < BPW; i++) begin
      if (beat_msk_d[BPW-1-i]) begin
        beat_dat_d[DW-1-8*i -: 8] = byte_d + 8'(i);
      end
    end
  end

  // In SEND a new beat may only replace an empty register or one that is being
  // accepted this cycle; the final beat's handshake ends the message instead.
  always_comb begin
    launch = 1'b0;
    case (state_q)
      IDLE:    launch = start;
      SEND:    launch = !(hs && lst_q) && (!vld_q || inpt.inpt_rdy) && launch_ok;
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_idx_q  <= '0;
      last_mask_q <= '0;
      beat_q      <= '0;
      byte_q      <= '0;
      vld_q       <= 1'b0;
      dat_q       <= '0;
      msk_q       <= '0;
      lst_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (launch) begin
        vld_q  <= 1'b1;
        dat_q  <= beat_dat_d;
        msk_q  <= beat_msk_d;
        lst_q  <= beat_lst_d;
        byte_q <= byte_d + 8'(BPW);
        beat_q <= (state_q == IDLE) ? LEN_W'(1) : beat_q + LEN_W'(1);
      end else if (hs) begin
        // Accepted with nothing new to launch (last beat or a bubble).
        vld_q <= 1'b0;
        dat_q <= '0;
        msk_q <= '0;
        lst_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            last_idx_q  <= cap_last_idx;
            last_mask_q <= cap_mask;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (hs && lst_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign inpt.inpt_vld      = vld_q;
  assign inpt.inpt_d        = dat_q;
  assign inpt.inpt_byte_vld = msk_q;
  assign inpt.inpt_lst      = lst_q;

endmodule

// File: tb/tb_sm3_inpt_drvr.sv
// Purpose : directed bench for sm3_inpt_drvr at DW=32 and DW=64.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : bench drives inpt_rdy, optionally with random stalls.
module tb_sm3_inpt_drvr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, start64;
  logic [15:0] len32, len64;
  logic [7:0]  seed32, seed64;
  logic        busy32, done32, busy64, done64;

  sm3_inpt_drvr_if #(.DW(32)) if32 ();
  sm3_inpt_drvr_if #(.DW(64)) if64 ();

  sm3_inpt_drvr #(.DW(32), .LEN_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .msg_len(len32), .seed(seed32),
    .busy(busy32), .done(done32), .inpt(if32)
  );

  sm3_inpt_drvr #(.DW(64), .LEN_W(16)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .msg_len(len64), .seed(seed64),
    .busy(busy64), .done(done64), .inpt(if64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  seed;
    logic [15:0] len;
    bit          stall;
    logic [31:0] first;
    logic [31:0] last;
    logic [3:0]  lmask;
    int          beats;
  } vec_t;

  vec_t vecs[6];

  // Reference beat n of a 32-bit message: byte k = seed + k while k < len, else 0.
  function automatic logic [36:0] exp_beat(input logic [7:0] s, input logic [15:0] len, input int n);
    logic [31:0] d;
    logic [3:0]  m;
    int          nb;
    d  = '0;
    m  = '0;
    nb = (len == 16'd0) ? 1 : (int'(len) + 3) / 4;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = n * 4 + i;
      if (k < int'(len)) begin
        d[31-8*i -: 8] = s + 8'(k);
        m[3-i]         = 1'b1;
      end
    end
    return {d, m, (n == nb - 1)};
  endfunction

  task automatic run32(input vec_t v, input string tag);
    int          beat, cyc, busy_cnt, nb;
    bit          got_done, lst_prev, rdy, pend;
    logic [31:0] first_d, last_d, pend_d;
    logic [3:0]  last_m;
    nb       = (v.len == 16'd0) ? 1 : (int'(v.len) + 3) / 4;
    beat     = 0;
    cyc      = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    lst_prev = 1'b0;
    pend     = 1'b0;
    first_d  = '0;
    last_d   = '0;
    pend_d   = '0;
    last_m   = '0;
    @(negedge clk);
    start32 = 1'b1; seed32 = v.seed; len32 = v.len; if32.inpt_rdy = 1'b0;
    @(negedge clk);
    start32 = 1'b0; seed32 = ~v.seed; len32 = 16'hFFFF;   // must be ignored after capture
    chk({tag, " first vld latency"}, 64'(if32.inpt_vld), 64'd1);
    while (!got_done && cyc < 3000) begin
      if (busy32) busy_cnt++;
      if (done32) begin
        got_done = 1'b1;
        chk({tag, " done after last hs"}, 64'({lst_prev, if32.inpt_vld}), 64'b10);
      end else begin
        if (pend) chk({tag, " held beat"}, 64'({if32.inpt_vld, if32.inpt_d}), 64'({1'b1, pend_d}));
        lst_prev = 1'b0;
        rdy = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if32.inpt_rdy = rdy;
        pend   = if32.inpt_vld && !rdy;
        pend_d = if32.inpt_d;
        if (if32.inpt_vld && rdy) begin
          if (beat == 0) first_d = if32.inpt_d;
          last_d = if32.inpt_d;
          last_m = if32.inpt_byte_vld;
          chk($sformatf("%s beat%0d", tag, beat),
              64'({if32.inpt_d, if32.inpt_byte_vld, if32.inpt_lst}),
              64'(exp_beat(v.seed, v.len, beat)));
          lst_prev = if32.inpt_lst;
          beat++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if32.inpt_rdy = 1'b0;
    chk({tag, " done seen in budget"}, 64'(got_done), 64'd1);
    chk({tag, " beat count"}, 64'(beat), 64'(v.beats));
    chk({tag, " beat count model"}, 64'(beat), 64'(nb));
    chk({tag, " first/last/mask"}, {first_d, last_d}, {v.first, v.last});
    chk({tag, " last mask"}, 64'(last_m), 64'(v.lmask));
    if (!v.stall) chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(v.beats + 1));
    @(negedge clk);
    chk({tag, " idle after done"}, 64'({busy32, done32, if32.inpt_vld}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vld_seen, done_seen;

    vecs[0] = '{8'h61, 16'd3,  1'b0, 32'h61626300, 32'h61626300, 4'hE, 1};
    vecs[1] = '{8'h00, 16'd64, 1'b0, 32'h00010203, 32'h3C3D3E3F, 4'hF, 16};
    vecs[2] = '{8'h00, 16'd0,  1'b0, 32'h00000000, 32'h00000000, 4'h0, 1};
    vecs[3] = '{8'hFE, 16'd6,  1'b1, 32'hFEFF0001, 32'h02030000, 4'hC, 2};
    vecs[4] = '{8'h10, 16'd8,  1'b1, 32'h10111213, 32'h14151617, 4'hF, 2};
    vecs[5] = '{8'hF0, 16'd33, 1'b1, 32'hF0F1F2F3, 32'h10000000, 4'h8, 9};

    rst_n = 1'b0;
    start32 = 1'b0; len32 = '0; seed32 = '0;
    start64 = 1'b0; len64 = '0; seed64 = '0;
    if32.inpt_rdy = 1'b0;
    if64.inpt_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset 32", 64'({busy32, done32, if32.inpt_vld, if32.inpt_d, if32.inpt_byte_vld, if32.inpt_lst}), 64'd0);
    chk("reset 64 d", if64.inpt_d, 64'd0);
    chk("reset 64 ctl", 64'({busy64, done64, if64.inpt_vld, if64.inpt_byte_vld, if64.inpt_lst}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run32(vecs[i], $sformatf("vec%0d", i));
    end

    // Beat 1 of an 8-byte message held through three not-ready cycles.
    @(negedge clk);
    start32 = 1'b1; seed32 = 8'h00; len32 = 16'd8; if32.inpt_rdy = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("hold beat0", 64'({if32.inpt_vld, if32.inpt_d}), 64'({1'b1, 32'h00010203}));
    @(negedge clk);
    chk("hold beat1 first", 64'({if32.inpt_vld, if32.inpt_d, if32.inpt_lst}), 64'({1'b1, 32'h04050607, 1'b1}));
    if32.inpt_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold beat1 stall%0d", k),
          64'({if32.inpt_vld, if32.inpt_d, if32.inpt_byte_vld, if32.inpt_lst}),
          64'({1'b1, 32'h04050607, 4'hF, 1'b1}));
      if (k == 2) if32.inpt_rdy = 1'b1;
    end
    @(negedge clk);
    chk("hold done", 64'({done32, if32.inpt_vld}), 64'b10);
    if32.inpt_rdy = 1'b0;
    @(negedge clk);
    chk("hold done pulse width", 64'({done32, busy32}), 64'd0);

    // DW=64 partial last beat across the 8'hFF wrap; a second start mid-message is ignored.
    @(negedge clk);
    start64 = 1'b1; seed64 = 8'hFE; len64 = 16'd5; if64.inpt_rdy = 1'b0;
    @(negedge clk);
    start64 = 1'b1; seed64 = 8'h00; len64 = 16'd40;
    chk("w64 beat d", if64.inpt_d, 64'hFEFF000102000000);
    chk("w64 beat ctl", 64'({if64.inpt_vld, if64.inpt_byte_vld, if64.inpt_lst}), 64'({1'b1, 8'hF8, 1'b1}));
    @(negedge clk);
    start64 = 1'b0;
    chk("w64 held d", if64.inpt_d, 64'hFEFF000102000000);
    chk("w64 busy", 64'(busy64), 64'd1);
    if64.inpt_rdy = 1'b1;
    @(negedge clk);
    chk("w64 done", 64'({done64, if64.inpt_vld, if64.inpt_lst}), 64'b100);
    vld_seen = 0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if64.inpt_vld) vld_seen++;
      if (done64) done_seen++;
    end
    chk("w64 no second message", 64'({vld_seen[7:0], done_seen[7:0]}), 64'd0);
    if64.inpt_rdy = 1'b0;

    // Reset while beat index 2 of a 64-byte message is on the bus.
    @(negedge clk);
    start32 = 1'b1; seed32 = 8'h00; len32 = 16'd64; if32.inpt_rdy = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst beat2 present", 64'({if32.inpt_vld, if32.inpt_d}), 64'({1'b1, 32'h08090A0B}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst outputs cleared",
        64'({busy32, done32, if32.inpt_vld, if32.inpt_d, if32.inpt_byte_vld, if32.inpt_lst}), 64'd0);
    rst_n = 1'b1;
    vld_seen = 0;
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if32.inpt_vld) vld_seen++;
      if (done32) done_seen++;
    end
    chk("rst no done no vld", 64'({vld_seen[7:0], done_seen[7:0]}), 64'd0);
    if32.inpt_rdy = 1'b0;
    run32(vecs[1], "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
